// File: rtl/add8_arb_pkg.sv
// add8_arb_pkg
// Shared constants, types and the round-robin search function used by the
// time-shared approximate adder (add8_apx_share_arb) and its core.
//   OP_W    operand width (8)
//   SUM_W   result width (9)
//   ERR_W   error-monitor register width (16)
//   rr_pick first valid index at or above ptr, wrapping at nreq
package add8_arb_pkg;

    localparam int OP_W    = 8;
    localparam int SUM_W   = 9;
    localparam int ERR_W   = 16;
    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;
    localparam int CAND_W  = IDX_W + 1;

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic [IDX_W-1:0] id;
    } arb_result_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Search starts at ptr and wraps at nreq. Because ptr < nreq and the
    // offset is < nreq, one conditional subtract performs the modulo.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [IDX_W-1:0]   ptr,
        input int                 nreq
    );
        rr_pick_t          r;
        logic [CAND_W-1:0] cand;
        r = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            cand = {1'b0, ptr} + CAND_W'(i);
            if (cand >= CAND_W'(nreq)) begin
                cand = cand - CAND_W'(nreq);
            end
            if ((i < nreq) && !r.found && valid[cand[IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = cand[IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/add8_apx_core.sv
// add8_apx_core
// Purely combinational approximate 8-bit adder. Low bits are passed through
// from the operands; only bits [7:5] are really added, with a carry-in
// guessed from bit 4 of both operands.
//   a, b  in   8-bit operands
//   sum   out  9-bit approximate sum
module add8_apx_core
    import add8_arb_pkg::*;
(
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [SUM_W-1:0] sum
);

    logic [3:0] hi;
    // Operand bits the approximation ignores by construction.
    logic       unused_bits;

    assign hi          = {1'b0, a[7:5]} + {1'b0, b[7:5]} + {3'b000, a[4] & b[4]};
    assign sum         = {hi, a[3], b[3], b[2], a[1], a[0]};
    assign unused_bits = ^{a[2], b[1:0]};

endmodule

// File: rtl/add8_apx_share_arb.sv
// add8_apx_share_arb
// Time-shares one add8_apx_core among NREQ requesters. A round-robin arbiter
// grants one valid request per cycle when the result register can take it;
// the approximate sum and the requester ID are registered one cycle later.
// Optional error monitor: define ADD8_ARB_ERRMON_EN to add err_clr, err_acc
// (saturating sum of |exact-approx|) and err_cnt (saturating count of
// transfers with nonzero error).
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_a, req_b          packed operands, requester i at [8i+7:8i]
//   out_valid/out_ready   result handshake
//   out_sum, out_id       approximate sum and producing requester
module add8_apx_share_arb
    import add8_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_a,
    input  logic [NREQ*OP_W-1:0] req_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SUM_W-1:0]     out_sum,
    output logic [IDW-1:0]       out_id
`ifdef ADD8_ARB_ERRMON_EN
    ,
    input  logic                 err_clr,
    output logic [ERR_W-1:0]     err_acc,
    output logic [ERR_W-1:0]     err_cnt
`endif
);

    logic             out_valid_reg;
    logic [SUM_W-1:0] out_sum_reg;
    logic [IDW-1:0]   out_id_reg;
    logic [IDW-1:0]   rr_ptr_reg;
    logic [IDW-1:0]   rr_ptr_next;

    logic             can_accept;
    rr_pick_t         pick;
    logic [IDX_W-1:0] g;
    logic             xfer;
    logic [OP_W-1:0]  a_sel;
    logic [OP_W-1:0]  b_sel;
    logic [SUM_W-1:0] apx_sum;

    assign can_accept = !out_valid_reg || out_ready;

    always_comb begin
        pick = rr_pick(MAX_REQ'(req_valid), IDX_W'(rr_ptr_reg), NREQ);
    end
    assign g = pick.idx;

    // rst_n gates ready so nothing is accepted while reset is held.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = rst_n && can_accept && pick.found && (g == IDX_W'(gi));
        end
    endgenerate

    assign xfer = |req_ready;

    // One-hot operand mux driven by the grant; zero when nothing is granted.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                a_sel = a_sel | req_a[i*OP_W +: OP_W];
                b_sel = b_sel | req_b[i*OP_W +: OP_W];
            end
        end
    end

    add8_apx_core u_core (
        .a   (a_sel),
        .b   (b_sel),
        .sum (apx_sum)
    );

    assign rr_ptr_next = (g == IDX_W'(NREQ - 1)) ? '0 : IDW'(g + IDX_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_sum_reg   <= '0;
            out_id_reg    <= '0;
            rr_ptr_reg    <= '0;
        end else begin
            if (xfer) begin
                // Also covers drain-and-refill in the same cycle.
                out_valid_reg <= 1'b1;
                out_sum_reg   <= apx_sum;
                out_id_reg    <= IDW'(g);
                rr_ptr_reg    <= rr_ptr_next;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_id    = out_id_reg;

`ifdef ADD8_ARB_ERRMON_EN
    logic [SUM_W-1:0] exact_sum;
    logic [SUM_W-1:0] abs_err;
    logic [ERR_W:0]   acc_sum;
    logic [ERR_W-1:0] err_acc_reg;
    logic [ERR_W-1:0] err_cnt_reg;

    assign exact_sum = {1'b0, a_sel} + {1'b0, b_sel};
    assign abs_err   = (exact_sum >= apx_sum) ? (exact_sum - apx_sum) : (apx_sum - exact_sum);
    assign acc_sum   = {1'b0, err_acc_reg} + (ERR_W+1)'(abs_err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_acc_reg <= '0;
            err_cnt_reg <= '0;
        end else if (err_clr) begin
            err_acc_reg <= '0;
            err_cnt_reg <= '0;
        end else if (xfer) begin
            err_acc_reg <= acc_sum[ERR_W] ? '1 : acc_sum[ERR_W-1:0];
            if ((abs_err != '0) && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    assign err_acc = err_acc_reg;
    assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_add8_apx_share_arb.sv
// tb_add8_apx_share_arb
// Directed bench for add8_apx_share_arb with NREQ=4. Expected sums are
// hand-computed from the approximate adder definition. Error-monitor checks
// are compiled in when ADD8_ARB_ERRMON_EN is defined.
module tb_add8_apx_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [31:0]     req_a;
    logic [31:0]     req_b;
    logic            out_valid;
    logic            out_ready;
    logic [8:0]      out_sum;
    logic [IDW-1:0]  out_id;
`ifdef ADD8_ARB_ERRMON_EN
    logic            err_clr;
    logic [15:0]     err_acc;
    logic [15:0]     err_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    add8_apx_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_id    (out_id)
`ifdef ADD8_ARB_ERRMON_EN
        ,
        .err_clr   (err_clr),
        .err_acc   (err_acc),
        .err_cnt   (err_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'hF;
        #2;
        if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++;
        if (out_sum !== 9'h000) $display("FAIL reset_sum got %h exp 000", out_sum); else n_pass++;
        n_checks++;
        if (out_id !== 2'd0) $display("FAIL reset_id got %0d exp 0", out_id); else n_pass++;
        n_checks++;
        tick();
        tick();
        if (req_ready !== 4'b0000) $display("FAIL reset_ready got %b exp 0000", req_ready); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid_held got %b exp 0", out_valid); else n_pass++;
        n_checks++;
        req_valid = 4'h0;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_single();
        tick();
        req_a[7:0] = 8'h10;
        req_b[7:0] = 8'h10;
        req_valid  = 4'b0001;
        #1;
        if (req_ready !== 4'b0001) $display("FAIL single_ready got %b exp 0001", req_ready); else n_pass++;
        n_checks++;
        tick();
        req_valid = 4'b0000;
        $display("txn single id=%0d sum=%h", out_id, out_sum);
        if (out_valid !== 1'b1) $display("FAIL single_valid got %b exp 1", out_valid); else n_pass++;
        n_checks++;
        if (out_sum !== 9'h020) $display("FAIL single_sum got %h exp 020", out_sum); else n_pass++;
        n_checks++;
        if (out_id !== 2'd0) $display("FAIL single_id got %0d exp 0", out_id); else n_pass++;
        n_checks++;
    endtask

    task automatic test_approx();
        req_a[23:16] = 8'hFF;
        req_b[23:16] = 8'h01;
        req_valid    = 4'b0100;
        #1;
        if (req_ready !== 4'b0100) $display("FAIL approx_ready got %b exp 0100", req_ready); else n_pass++;
        n_checks++;
        tick();
        req_valid = 4'b0000;
        $display("txn approx id=%0d sum=%h", out_id, out_sum);
        if (out_sum !== 9'h0F3) $display("FAIL approx_sum got %h exp 0f3", out_sum); else n_pass++;
        n_checks++;
        if (out_id !== 2'd2) $display("FAIL approx_id got %0d exp 2", out_id); else n_pass++;
        n_checks++;
`ifdef ADD8_ARB_ERRMON_EN
        if (err_acc !== 16'd13) $display("FAIL approx_err_acc got %0d exp 13", err_acc); else n_pass++;
        n_checks++;
        if (err_cnt !== 16'd1) $display("FAIL approx_err_cnt got %0d exp 1", err_cnt); else n_pass++;
        n_checks++;
        // Clear wins over an accumulating transfer in the same cycle.
        req_valid = 4'b0100;
        err_clr   = 1'b1;
        tick();
        err_clr   = 1'b0;
        req_valid = 4'b0000;
        if (err_acc !== 16'd0) $display("FAIL errclr_acc got %0d exp 0", err_acc); else n_pass++;
        n_checks++;
        if (err_cnt !== 16'd0) $display("FAIL errclr_cnt got %0d exp 0", err_cnt); else n_pass++;
        n_checks++;
`endif
        tick();
        if (out_valid !== 1'b0) $display("FAIL drain_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++;
        if (out_sum !== 9'h0F3) $display("FAIL drain_sum_hold got %h exp 0f3", out_sum); else n_pass++;
        n_checks++;
        if (out_id !== 2'd2) $display("FAIL drain_id_hold got %0d exp 2", out_id); else n_pass++;
        n_checks++;
    endtask

    task automatic test_rotation();
        logic [8:0] exp_sum [4];
        int         pulses  [4];
        logic [3:0] exp_rdy;
        int         e;
        exp_sum = '{9'h021, 9'h042, 9'h063, 9'h090};
        pulses  = '{0, 0, 0, 0};
        req_a   = 32'h88634221;
        req_b   = 32'h00000000;
        // Pointer sits at 3 here; one lone request from lane 3 returns it to 0.
        req_valid = 4'b1000;
        #1;
        if (req_ready !== 4'b1000) $display("FAIL rot_pre_ready got %b exp 1000", req_ready); else n_pass++;
        n_checks++;
        tick();
        if (out_sum !== 9'h090) $display("FAIL rot_pre_sum got %h exp 090", out_sum); else n_pass++;
        n_checks++;
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            e       = k % 4;
            exp_rdy = 4'b0001 << e;
            #1;
            if (req_ready !== exp_rdy) $display("FAIL rot_ready[%0d] got %b exp %b", k, req_ready, exp_rdy); else n_pass++;
            n_checks++;
            for (int i = 0; i < 4; i++) if (req_ready[i]) pulses[i]++;
            tick();
            $display("txn rotation id=%0d sum=%h", out_id, out_sum);
            if (out_id !== IDW'(e)) $display("FAIL rot_id[%0d] got %0d exp %0d", k, out_id, e); else n_pass++;
            n_checks++;
            if (out_sum !== exp_sum[e]) $display("FAIL rot_sum[%0d] got %h exp %h", k, out_sum, exp_sum[e]); else n_pass++;
            n_checks++;
        end
        req_valid = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (pulses[i] != 2) $display("FAIL rot_pulses[%0d] got %0d exp 2", i, pulses[i]); else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (req_ready !== 4'b0000) $display("FAIL bp_ready[%0d] got %b exp 0000", k, req_ready); else n_pass++;
            n_checks++;
            tick();
            if (out_valid !== 1'b1 || out_id !== 2'd3 || out_sum !== 9'h090)
                $display("FAIL bp_hold[%0d] got v=%b id=%0d sum=%h exp v=1 id=3 sum=090", k, out_valid, out_id, out_sum);
            else n_pass++;
            n_checks++;
        end
        out_ready = 1'b1;
        #1;
        if (req_ready !== 4'b0010) $display("FAIL bp_release_ready got %b exp 0010", req_ready); else n_pass++;
        n_checks++;
        tick();
        req_valid = 4'h0;
        $display("txn backpressure id=%0d sum=%h", out_id, out_sum);
        if (out_valid !== 1'b1 || out_id !== 2'd1 || out_sum !== 9'h042)
            $display("FAIL bp_refill got v=%b id=%0d sum=%h exp v=1 id=1 sum=042", out_valid, out_id, out_sum);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_wrap_skip();
        logic [1:0] seq [3];
        logic [8:0] sums [4];
        logic [3:0] exp_rdy;
        seq  = '{2'd3, 2'd1, 2'd3};
        sums = '{9'h021, 9'h042, 9'h063, 9'h090};
        // Pointer sits at 2; a lone lane-2 request moves it to 3.
        req_valid = 4'b0100;
        #1;
        if (req_ready !== 4'b0100) $display("FAIL wrap_pre_ready got %b exp 0100", req_ready); else n_pass++;
        n_checks++;
        tick();
        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            exp_rdy = 4'b0001 << seq[k];
            #1;
            if (req_ready !== exp_rdy) $display("FAIL wrap_ready[%0d] got %b exp %b", k, req_ready, exp_rdy); else n_pass++;
            n_checks++;
            tick();
            $display("txn wrap id=%0d sum=%h", out_id, out_sum);
            if (out_id !== seq[k] || out_sum !== sums[seq[k]])
                $display("FAIL wrap_out[%0d] got id=%0d sum=%h exp id=%0d sum=%h", k, out_id, out_sum, seq[k], sums[seq[k]]);
            else n_pass++;
            n_checks++;
        end
        req_valid = 4'h0;
    endtask

    task automatic test_async_reset();
        // Lane 1 transfer leaves the pointer at 2, so a pointer that survived
        // reset would grant lane 3 instead of lane 1 afterwards.
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1010;
        if (out_valid !== 1'b1 || out_id !== 2'd1) $display("FAIL arst_pre got v=%b id=%0d exp v=1 id=1", out_valid, out_id); else n_pass++;
        n_checks++;
        #2 rst_n = 1'b0;
        #1;
        if (out_valid !== 1'b0) $display("FAIL arst_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++;
        if (out_sum !== 9'h000 || out_id !== 2'd0) $display("FAIL arst_regs got sum=%h id=%0d exp 000/0", out_sum, out_id); else n_pass++;
        n_checks++;
        if (req_ready !== 4'b0000) $display("FAIL arst_ready got %b exp 0000", req_ready); else n_pass++;
        n_checks++;
        #1 rst_n = 1'b1;
        #1;
        if (req_ready !== 4'b0010) $display("FAIL arst_first_grant got %b exp 0010", req_ready); else n_pass++;
        n_checks++;
        tick();
        req_valid = 4'h0;
        $display("txn post_reset id=%0d sum=%h", out_id, out_sum);
        if (out_id !== 2'd1 || out_sum !== 9'h042) $display("FAIL arst_out got id=%0d sum=%h exp 1/042", out_id, out_sum); else n_pass++;
        n_checks++;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        out_ready = 1'b1;
`ifdef ADD8_ARB_ERRMON_EN
        err_clr   = 1'b0;
`endif
        test_reset();
        test_single();
        test_approx();
        test_rotation();
        test_backpressure();
        test_wrap_skip();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
